// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: result select, load extension, regfile and CSR writes.
// Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter.
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module wb_retire_unit #(
    parameter int XLEN = `XLEN_64b,
    localparam int W = 1 << (XLEN + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid_w,
    input  logic [W-1:0] i_alu_out_w,
    input  logic [W-1:0] i_mem_out_w,
    input  logic [W-1:0] i_pc_p4_w,
    input  logic [W-1:0] i_old_csr_w,
    input  logic [W-1:0] i_new_csr_w,
    input  logic [11:0]  i_csr_rd_w,
    input  logic         i_csr_reg_write_w,
    input  logic [4:0]   i_rd_w,
    input  logic         i_reg_wr_w,
    input  logic [1:0]   i_result_src_w,
    input  logic [2:0]   i_f3_w,
    input  logic         i_csr_wr_ready,
    output logic         o_rf_we,
    output logic [4:0]   o_rf_waddr,
    output logic [W-1:0] o_rf_wdata,
    output logic         o_csr_wr_valid,
    output logic [11:0]  o_csr_wr_addr,
    output logic [W-1:0] o_csr_wr_data,
    output logic         o_stall_w,
    output logic         o_retire,
    output logic [63:0]  o_instret
);

    typedef enum logic {
        IDLE,
        CSR_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [11:0]  hold_addr;
    logic [W-1:0] hold_data;
    logic [4:0]   hold_rd;
    logic         hold_reg_wr;
    logic [W-1:0] hold_result;
    logic         latch;

    logic [W-1:0] load_val;
    logic [W-1:0] result;

    // W=32 has no doubleword loads: LD/LWU collapse to LW.
    always_comb begin
        load_val = i_mem_out_w;
        case (i_f3_w)
            3'b000: load_val = W'($signed(i_mem_out_w[7:0]));
            3'b001: load_val = W'($signed(i_mem_out_w[15:0]));
            3'b010: load_val = W'($signed(i_mem_out_w[31:0]));
            3'b011: load_val = (W == 64) ? i_mem_out_w
                                         : W'($signed(i_mem_out_w[31:0]));
            3'b100: load_val = W'(i_mem_out_w[7:0]);
            3'b101: load_val = W'(i_mem_out_w[15:0]);
            3'b110: load_val = (W == 64) ? W'(i_mem_out_w[31:0])
                                         : W'($signed(i_mem_out_w[31:0]));
            default: load_val = i_mem_out_w;
        endcase
    end

    always_comb begin
        result = i_alu_out_w;
        unique case (1'b1)
            i_result_src_w == 2'b00: result = i_alu_out_w;
            i_result_src_w == 2'b01: result = load_val;
            i_result_src_w == 2'b10: result = i_pc_p4_w;
            i_result_src_w == 2'b11: result = i_old_csr_w;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        latch          = 1'b0;
        o_rf_we        = 1'b0;
        o_rf_waddr     = '0;
        o_rf_wdata     = '0;
        o_csr_wr_valid = 1'b0;
        o_csr_wr_addr  = '0;
        o_csr_wr_data  = '0;
        o_stall_w      = 1'b0;
        o_retire       = 1'b0;
        if (i_rst) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid_w) begin
                        if (i_csr_reg_write_w) begin
                            o_csr_wr_valid = 1'b1;
                            o_csr_wr_addr  = i_csr_rd_w;
                            o_csr_wr_data  = i_new_csr_w;
                        end
                        if (!i_csr_reg_write_w || i_csr_wr_ready) begin
                            o_retire   = 1'b1;
                            o_rf_we    = i_reg_wr_w && (i_rd_w != 5'd0);
                            o_rf_waddr = i_rd_w;
                            o_rf_wdata = result;
                        end else begin
                            latch     = 1'b1;
                            o_stall_w = 1'b1;
                            state_d   = CSR_WAIT;
                        end
                    end
                end
                CSR_WAIT: begin
                    // Request replays from the hold regs so it stays stable.
                    o_csr_wr_valid = 1'b1;
                    o_csr_wr_addr  = hold_addr;
                    o_csr_wr_data  = hold_data;
                    o_stall_w      = !i_csr_wr_ready;
                    if (i_csr_wr_ready) begin
                        o_retire   = 1'b1;
                        o_rf_we    = hold_reg_wr && (hold_rd != 5'd0);
                        o_rf_waddr = hold_rd;
                        o_rf_wdata = hold_result;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            hold_addr   <= '0;
            hold_data   <= '0;
            hold_rd     <= '0;
            hold_reg_wr <= 1'b0;
            hold_result <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                hold_addr   <= i_csr_rd_w;
                hold_data   <= i_new_csr_w;
                hold_rd     <= i_rd_w;
                hold_reg_wr <= i_reg_wr_w;
                hold_result <= result;
            end
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            instret_q <= '0;
        end else if (o_retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign o_instret = i_rst ? 64'd0 : instret_q;
`else
    assign o_instret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_retire_unit.sv
// Directed-vector bench for wb_retire_unit (64-bit build).
// Counter expectations follow WB_INSTRET_EN.
module tb_wb_retire_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [63:0] alu_out, mem_out, pc_p4, old_csr, new_csr;
    logic [11:0] csr_rd;
    logic        csr_we;
    logic [4:0]  rd;
    logic        reg_wr;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic        ready;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        csr_v;
    logic [11:0] csr_a;
    logic [63:0] csr_d;
    logic        stall;
    logic        retire;
    logic [63:0] instret;

    int n_tests = 0;
    int n_fail  = 0;
    longint unsigned exp_cnt = 0;

    always #5 clk = ~clk;

    wb_retire_unit dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_valid_w         (valid),
        .i_alu_out_w       (alu_out),
        .i_mem_out_w       (mem_out),
        .i_pc_p4_w         (pc_p4),
        .i_old_csr_w       (old_csr),
        .i_new_csr_w       (new_csr),
        .i_csr_rd_w        (csr_rd),
        .i_csr_reg_write_w (csr_we),
        .i_rd_w            (rd),
        .i_reg_wr_w        (reg_wr),
        .i_result_src_w    (src),
        .i_f3_w            (f3),
        .i_csr_wr_ready    (ready),
        .o_rf_we           (rf_we),
        .o_rf_waddr        (rf_waddr),
        .o_rf_wdata        (rf_wdata),
        .o_csr_wr_valid    (csr_v),
        .o_csr_wr_addr     (csr_a),
        .o_csr_wr_data     (csr_d),
        .o_stall_w         (stall),
        .o_retire          (retire),
        .o_instret         (instret)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_instret();
`ifdef WB_INSTRET_EN
        return exp_cnt;
`else
        return 64'd0;
`endif
    endfunction

    task automatic idle_in();
        valid   = 1'b0;
        alu_out = '0;
        mem_out = '0;
        pc_p4   = '0;
        old_csr = '0;
        new_csr = '0;
        csr_rd  = '0;
        csr_we  = 1'b0;
        rd      = '0;
        reg_wr  = 1'b0;
        src     = 2'b00;
        f3      = 3'b000;
        ready   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] f, input logic [63:0] m,
                        input logic [63:0] exp, input string tag);
        idle_in();
        valid   = 1'b1;
        src     = 2'b01;
        f3      = f;
        mem_out = m;
        rd      = 5'd9;
        reg_wr  = 1'b1;
        #1;
        chk(tag, rf_wdata, exp);
        tick();
        exp_cnt++;
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        valid = 1'b1;
        alu_out = 64'h55;
        rd = 5'd4;
        reg_wr = 1'b1;
        #2;
        chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
        chk("rst_retire", {63'd0, retire}, 64'd0);
        tick();
        tick();
        chk("rst_instret", instret, 64'd0);
        chk("rst_csr_v", {63'd0, csr_v}, 64'd0);
        rst = 1'b0;
        idle_in();

        // No valid instruction: nothing leaves the stage
        alu_out = 64'hDEAD;
        rd = 5'd6;
        reg_wr = 1'b1;
        #1;
        chk("idle_rf_we", {63'd0, rf_we}, 64'd0);
        chk("idle_retire", {63'd0, retire}, 64'd0);
        chk("idle_stall", {63'd0, stall}, 64'd0);
        tick();

        // LB sign-extension
        idle_in();
        valid = 1'b1;
        src = 2'b01;
        f3 = 3'b000;
        mem_out = 64'h80;
        rd = 5'd5;
        reg_wr = 1'b1;
        #1;
        chk("lb_we", {63'd0, rf_we}, 64'd1);
        chk("lb_waddr", {59'd0, rf_waddr}, 64'd5);
        chk("lb_wdata", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_retire", {63'd0, retire}, 64'd1);
        chk("lb_stall", {63'd0, stall}, 64'd0);
        tick();
        exp_cnt++;
        chk("lb_instret", instret, exp_instret());

        load(3'b101, 64'h1234_8001, 64'h8001, "lhu");
        load(3'b110, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000, "lwu");
        load(3'b010, 64'h0000_0000_8000_0000,
             64'hFFFF_FFFF_8000_0000, "lw");
        load(3'b011, 64'h8123_4567_89AB_CDEF,
             64'h8123_4567_89AB_CDEF, "ld");
        load(3'b100, 64'h1FF, 64'hFF, "lbu");
        load(3'b001, 64'h8000, 64'hFFFF_FFFF_FFFF_8000, "lh");
        load(3'b111, 64'hA5A5_0000_0000_00FF,
             64'hA5A5_0000_0000_00FF, "f3_111");

        // ALU write to x0 still retires
        idle_in();
        valid = 1'b1;
        alu_out = 64'h55;
        rd = 5'd0;
        reg_wr = 1'b1;
        #1;
        chk("x0_we", {63'd0, rf_we}, 64'd0);
        chk("x0_retire", {63'd0, retire}, 64'd1);
        tick();
        exp_cnt++;
        chk("x0_instret", instret, exp_instret());

        // JAL link value
        idle_in();
        valid = 1'b1;
        src = 2'b10;
        pc_p4 = 64'h1004;
        alu_out = 64'h77;
        rd = 5'd1;
        reg_wr = 1'b1;
        #1;
        chk("jal_wdata", rf_wdata, 64'h1004);
        chk("jal_waddr", {59'd0, rf_waddr}, 64'd1);
        tick();
        exp_cnt++;

        // CSRRW with CSR file stalling for three cycles
        idle_in();
        valid = 1'b1;
        csr_we = 1'b1;
        csr_rd = 12'h300;
        new_csr = 64'hA;
        old_csr = 64'h7;
        src = 2'b11;
        rd = 5'd3;
        reg_wr = 1'b1;
        ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("csr_stall", {63'd0, stall}, 64'd1);
            chk("csr_valid", {63'd0, csr_v}, 64'd1);
            chk("csr_addr", {52'd0, csr_a}, 64'h300);
            chk("csr_data", csr_d, 64'hA);
            chk("csr_wait_we", {63'd0, rf_we}, 64'd0);
            chk("csr_wait_ret", {63'd0, retire}, 64'd0);
            tick();
            // Live inputs wander; the request must come from the held copy
            csr_rd = 12'h123;
            new_csr = 64'hBB;
            old_csr = 64'hCC;
            rd = 5'd17;
        end
        chk("csr_wait_cnt", instret, exp_instret());
        ready = 1'b1;
        #1;
        chk("csr_acc_stall", {63'd0, stall}, 64'd0);
        chk("csr_acc_valid", {63'd0, csr_v}, 64'd1);
        chk("csr_acc_addr", {52'd0, csr_a}, 64'h300);
        chk("csr_acc_data", csr_d, 64'hA);
        chk("csr_acc_we", {63'd0, rf_we}, 64'd1);
        chk("csr_acc_waddr", {59'd0, rf_waddr}, 64'd3);
        chk("csr_acc_wdata", rf_wdata, 64'h7);
        chk("csr_acc_ret", {63'd0, retire}, 64'd1);
        tick();
        exp_cnt++;
        idle_in();
        #1;
        chk("csr_after_ret", {63'd0, retire}, 64'd0);
        chk("csr_after_we", {63'd0, rf_we}, 64'd0);
        chk("csr_after_cnt", instret, exp_instret());
        tick();

        // CSR write accepted at once
        idle_in();
        valid = 1'b1;
        csr_we = 1'b1;
        csr_rd = 12'h341;
        new_csr = 64'h2000;
        old_csr = 64'h1000;
        src = 2'b11;
        rd = 5'd8;
        reg_wr = 1'b1;
        ready = 1'b1;
        #1;
        chk("csr0_valid", {63'd0, csr_v}, 64'd1);
        chk("csr0_addr", {52'd0, csr_a}, 64'h341);
        chk("csr0_stall", {63'd0, stall}, 64'd0);
        chk("csr0_wdata", rf_wdata, 64'h1000);
        chk("csr0_ret", {63'd0, retire}, 64'd1);
        tick();
        exp_cnt++;
        chk("csr0_cnt", instret, exp_instret());

        // Reset while waiting on the CSR file
        ready = 1'b0;
        #1;
        chk("rw_stall", {63'd0, stall}, 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        ready = 1'b1;
        valid = 1'b0;
        #1;
        chk("rw_csr_v", {63'd0, csr_v}, 64'd0);
        chk("rw_stall0", {63'd0, stall}, 64'd0);
        chk("rw_rf_we", {63'd0, rf_we}, 64'd0);
        chk("rw_retire", {63'd0, retire}, 64'd0);
        chk("rw_instret", instret, 64'd0);
        tick();

        // Ten back-to-back ALU retires
        for (int i = 0; i < 10; i++) begin
            idle_in();
            valid = 1'b1;
            alu_out = 64'h100 + 64'(i);
            rd = 5'd7;
            reg_wr = 1'b1;
            #1;
            chk("burst_we", {63'd0, rf_we}, 64'd1);
            chk("burst_wdata", rf_wdata, 64'h100 + 64'(i));
            tick();
            exp_cnt++;
        end
        idle_in();
        #1;
        chk("burst_instret", instret, exp_instret());
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
